// File: rtl/gate_seq_pkg.sv
// Shared types and golden reference for the gate-vector sequencer.
//   state_t       : sequencer FSM states
//   mode_t        : reference cell selection (NOR / OAI)
//   gate_expected : golden output for a vector, zero-extended to MAX_N_IN bits
package gate_seq_pkg;

  localparam int unsigned MAX_N_IN = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  typedef enum logic {
    MODE_NOR,
    MODE_OAI
  } mode_t;

  // Vectors narrower than MAX_N_IN arrive zero-extended; the zero upper bits
  // leave both the NOR and the OAI reduction unchanged.
  function automatic logic gate_expected(input logic [MAX_N_IN-1:0] vec,
                                         input mode_t mode);
    logic w_y;
    if (mode == MODE_OAI) begin
      w_y = ~((|vec[MAX_N_IN-1:1]) & vec[0]);
    end else begin
      w_y = ~(|vec);
    end
    return w_y;
  endfunction

endpackage

// File: rtl/gate_vector_sequencer_ref.sv
// Combinational golden model for the cell under test.
//   i_vec  : vector currently applied to the cell
//   i_mode : reference cell selection
//   o_exp  : expected cell output
module gate_ref_model
  import gate_seq_pkg::*;
#(
  parameter int unsigned N_IN = 3
) (
  input  logic [N_IN-1:0] i_vec,
  input  mode_t           i_mode,
  output logic            o_exp
);

  logic [MAX_N_IN-1:0] w_vec_ext;

  always_comb begin
    w_vec_ext            = '0;
    w_vec_ext[N_IN-1:0]  = i_vec;
    o_exp                = gate_expected(w_vec_ext, i_mode);
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Clocked stimulus engine: sweeps every N_IN-bit vector into a gate cell,
// holds each for SETTLE_CYCLES+1 cycles, samples the cell and compares it
// with the built-in golden model.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin a sweep (IDLE only)
//   abort          : end a sweep early (SETTLE/SAMPLE only)
//   mode           : 0 = NOR reference, 1 = OAI reference, latched at start
//   dut_vec        : vector driven to the cell
//   dut_y          : cell output
//   busy           : sweep in progress
//   done, aborted  : one-cycle completion pulse; aborted qualifies it
//   err_cnt        : saturating mismatch count
//   first_err_vec  : vector of the first mismatch, valid with first_err_vld
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned N_IN          = 3,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  output logic [N_IN-1:0]  dut_vec,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_vld
);

  localparam int unsigned      CNT_W    = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [N_IN-1:0]  r_vec;
  mode_t            r_mode;
  logic [ERR_W-1:0] r_err;
  logic [N_IN-1:0]  r_fe_vec;
  logic             r_fe_vld;
  logic             r_aborted;

  logic             w_exp;
  logic             w_go;
  logic             w_abort;
  logic             w_sample;

  gate_ref_model #(
    .N_IN (N_IN)
  ) u_ref (
    .i_vec  (r_vec),
    .i_mode (r_mode),
    .o_exp  (w_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort is checked ahead of the sample so that an aborted SAMPLE cycle
  // neither counts an error nor advances the vector.
  always_comb begin
    w_next   = r_state;
    w_go     = 1'b0;
    w_abort  = 1'b0;
    w_sample = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = SETTLE;
          w_go   = 1'b1;
        end
      end
      SETTLE: begin
        if (abort) begin
          w_next  = DONE;
          w_abort = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_next = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          w_next  = DONE;
          w_abort = 1'b1;
        end else begin
          w_sample = 1'b1;
          w_next   = (r_vec == '1) ? DONE : SETTLE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_vec     <= '0;
      r_mode    <= MODE_NOR;
      r_err     <= '0;
      r_fe_vec  <= '0;
      r_fe_vld  <= 1'b0;
      r_aborted <= 1'b0;
    end else if (w_go) begin
      r_cnt     <= '0;
      r_vec     <= '0;
      r_mode    <= mode_t'(mode);
      r_err     <= '0;
      r_fe_vld  <= 1'b0;
      r_aborted <= 1'b0;
    end else if (w_abort) begin
      r_aborted <= 1'b1;
    end else if (r_state == SETTLE) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_sample) begin
      if (dut_y != w_exp) begin
        if (r_err != '1) begin
          r_err <= r_err + 1'b1;
        end
        if (!r_fe_vld) begin
          r_fe_vec <= r_vec;
          r_fe_vld <= 1'b1;
        end
      end
      // The last vector stays on dut_vec; the counter never wraps.
      if (r_vec != '1) begin
        r_vec <= r_vec + 1'b1;
        r_cnt <= '0;
      end
    end
  end

  assign dut_vec       = r_vec;
  assign busy          = (r_state == SETTLE) || (r_state == SAMPLE);
  assign done          = (r_state == DONE);
  assign aborted       = r_aborted;
  assign err_cnt       = r_err;
  assign first_err_vec = r_fe_vec;
  assign first_err_vld = r_fe_vld;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
module tb_gate_vector_sequencer;

  localparam int HOLD = 5;  // SETTLE_CYCLES + 1
  localparam int NVEC = 8;  // 2^N_IN

  localparam int K_OAI = 0;
  localparam int K_NOR = 1;
  localparam int K_ST0 = 2;
  localparam int K_ST1 = 3;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       mode;
  int         kind;

  logic [2:0] vec_a, fe_vec_a;
  logic       y_a, busy_a, done_a, ab_a, fe_vld_a;
  logic [7:0] err_a;

  logic [2:0] vec_b, fe_vec_b;
  logic       y_b, busy_b, done_b, ab_b, fe_vld_b;
  logic [1:0] err_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  gate_vector_sequencer #(
    .N_IN          (3),
    .SETTLE_CYCLES (4),
    .ERR_W         (8)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .mode          (mode),
    .dut_vec       (vec_a),
    .dut_y         (y_a),
    .busy          (busy_a),
    .done          (done_a),
    .aborted       (ab_a),
    .err_cnt       (err_a),
    .first_err_vec (fe_vec_a),
    .first_err_vld (fe_vld_a)
  );

  gate_vector_sequencer #(
    .N_IN          (3),
    .SETTLE_CYCLES (4),
    .ERR_W         (2)
  ) u_dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .mode          (mode),
    .dut_vec       (vec_b),
    .dut_y         (y_b),
    .busy          (busy_b),
    .done          (done_b),
    .aborted       (ab_b),
    .err_cnt       (err_b),
    .first_err_vec (fe_vec_b),
    .first_err_vld (fe_vld_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behaviour of the cell under test, selected by kind.
  function automatic logic cell_y(input int k, input int v);
    case (k)
      K_OAI:   return !((v % 2 == 1) && (v > 1));
      K_NOR:   return (v == 0);
      K_ST0:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Truth table of the reference cells as integer rules.
  function automatic logic golden(input int v, input int m);
    if (m != 0) return !((v % 2 == 1) && (v > 1));
    return (v == 0);
  endfunction

  always_comb y_a = cell_y(kind, int'(vec_a));
  always_comb y_b = cell_y(kind, int'(vec_b));

  // Sweep model: time since start decides the vector and the sample points.
  int m_active, m_done, m_aborted, m_t, m_mode;
  int m_vec, m_err, m_fe_vec, m_fe_vld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_aborted = 0; m_t = 0; m_mode = 0;
      m_vec = 0; m_err = 0; m_fe_vec = 0; m_fe_vld = 0;
    end else if (m_active != 0) begin
      if (abort) begin
        m_active = 0; m_done = 1; m_aborted = 1;
      end else begin
        if (m_t % HOLD == HOLD - 1) begin
          if (cell_y(kind, m_t / HOLD) != golden(m_t / HOLD, m_mode)) begin
            m_err++;
            if (m_fe_vld == 0) begin
              m_fe_vec = m_t / HOLD;
              m_fe_vld = 1;
            end
          end
          if (m_t / HOLD == NVEC - 1) begin
            m_active = 0; m_done = 1;
          end else begin
            m_vec = m_t / HOLD + 1;
          end
        end
        m_t++;
      end
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (start) begin
      m_active = 1; m_t = 0; m_mode = int'(mode);
      m_vec = 0; m_err = 0; m_fe_vld = 0; m_aborted = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy",          int'(busy_a),   m_active);
    chk("done",          int'(done_a),   m_done);
    chk("aborted",       int'(ab_a),     m_aborted);
    chk("dut_vec",       int'(vec_a),    m_vec);
    chk("err_cnt",       int'(err_a),    (m_err > 255) ? 255 : m_err);
    chk("first_err_vec", int'(fe_vec_a), m_fe_vec);
    chk("first_err_vld", int'(fe_vld_a), m_fe_vld);
    chk("sat_err_cnt",   int'(err_b),    (m_err > 3) ? 3 : m_err);
    chk("sat_done",      int'(done_b),   m_done);
    chk("sat_dut_vec",   int'(vec_b),    m_vec);
  end

  task automatic start_sweep(output int s_cyc);
    @(posedge clk); #2;
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int d_cyc);
    int n;
    n = 0;
    d_cyc = -1;
    while (n < budget && d_cyc < 0) begin
      @(negedge clk);
      n++;
      if (done_a) d_cyc = cyc;
    end
    if (d_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_%0d", budget);
    end
  endtask

  int s, d, a;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; kind = K_OAI;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_vec",  int'(vec_a),  0);
    chk("reset_err",  int'(err_a),  0);

    // Correct OAI cell; a second start mid-sweep must be ignored.
    kind = K_OAI; mode = 1'b1;
    start_sweep(s);
    repeat (12) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done(80, d);
    chk("oai_latency",  d - s,             41);
    chk("oai_err",      int'(err_a),       0);
    chk("oai_fe_vld",   int'(fe_vld_a),    0);
    chk("oai_aborted",  int'(ab_a),        0);

    // OAI reference, stuck-at-0 cell.
    kind = K_ST0; mode = 1'b1;
    start_sweep(s);
    wait_done(80, d);
    chk("st0_err",     int'(err_a),    5);
    chk("st0_fe_vec",  int'(fe_vec_a), 0);
    chk("st0_fe_vld",  int'(fe_vld_a), 1);

    // NOR reference, stuck-at-1 cell; 2-bit counter saturates.
    kind = K_ST1; mode = 1'b0;
    start_sweep(s);
    wait_done(80, d);
    chk("st1_err",     int'(err_a),    7);
    chk("st1_fe_vec",  int'(fe_vec_a), 1);
    chk("st1_sat_err", int'(err_b),    3);
    chk("st1_idle_vec_hold", int'(vec_a), 7);

    // Abort during SETTLE of vector 2.
    start_sweep(s);
    repeat (11) @(posedge clk);
    #2 abort = 1'b1;
    a = cyc;
    @(posedge clk); #2 abort = 1'b0;
    @(negedge clk);
    chk("abort_latency", cyc - a,         1);
    chk("abort_done",    int'(done_a),    1);
    chk("abort_flag",    int'(ab_a),      1);
    chk("abort_vec",     int'(vec_a),     2);
    chk("abort_err",     int'(err_a),     1);

    // Restart with start and abort together: start wins.
    kind = K_NOR; mode = 1'b0;
    @(posedge clk); #2;
    start = 1'b1; abort = 1'b1;
    s = cyc;
    @(posedge clk); #2;
    start = 1'b0; abort = 1'b0;
    wait_done(80, d);
    chk("restart_latency", d - s,          41);
    chk("restart_err",     int'(err_a),    0);
    chk("restart_aborted", int'(ab_a),     0);

    // Reset while vector 5 is applied.
    kind = K_OAI; mode = 1'b1;
    start_sweep(s);
    repeat (27) @(posedge clk);
    #1 chk("pre_reset_vec", int'(vec_a), 5);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_vec",  int'(vec_a),  0);
    chk("rst_done", int'(done_a), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    start_sweep(s);
    wait_done(80, d);
    chk("post_rst_latency", d - s,       41);
    chk("post_rst_err",     int'(err_a), 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
